// File: rtl/bus_arbiter4_if.sv
// Bundle of the request/data/grant signals shared between the four requesters
// and the round-robin bus arbiter.
interface bus_arbiter4_if #(
  parameter int DATA_BITS = 8
);
  logic [3:0]           req;
  logic [DATA_BITS-1:0] in0;
  logic [DATA_BITS-1:0] in1;
  logic [DATA_BITS-1:0] in2;
  logic [DATA_BITS-1:0] in3;
  logic [3:0]           gnt;
  logic [1:0]           sel;
  logic                 busy;
  logic [DATA_BITS-1:0] bus_out;

  modport master (
    output req, in0, in1, in2, in3,
    input  gnt, sel, busy, bus_out
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output gnt, sel, busy, bus_out
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with a hold limit; the registered owner
// index steers a 4:1 data mux onto the shared bus.
module bus_arbiter4 #(
  parameter int DATA_BITS = 8,
  parameter int MAX_HOLD  = 4
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter4_if.slave bus
);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic       busy_reg, busy_next;
  logic [1:0] last_reg, last_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;

  logic [DATA_BITS-1:0] data_arr [4];
  logic [3:0] owner_mask;
  logic [3:0] idle_win_oh;
  logic [3:0] rot_win_oh;
  logic [1:0] idle_win;
  logic [1:0] rot_win;
  logic       others_req;

  // First set bit of r scanning upward from base+1, wrapping; base itself last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int off = 4; off >= 1; off--) begin
      idx = base + 2'(off);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign data_arr[0] = bus.in0;
  assign data_arr[1] = bus.in1;
  assign data_arr[2] = bus.in2;
  assign data_arr[3] = bus.in3;

  assign idle_win = rr_pick(bus.req, last_reg);
  // Masking the owner out makes hand-over and forced rotation share one search.
  assign rot_win  = rr_pick(bus.req & ~owner_mask, sel_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      assign owner_mask[gi]  = (sel_reg == 2'(gi));
      assign idle_win_oh[gi] = (idle_win == 2'(gi));
      assign rot_win_oh[gi]  = (rot_win == 2'(gi));
    end
  endgenerate

  assign others_req = |(bus.req & ~owner_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      gnt_reg      <= 4'b0000;
      sel_reg      <= 2'd0;
      busy_reg     <= 1'b0;
      last_reg     <= 2'd3;
      hold_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      busy_reg     <= busy_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    busy_next     = busy_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next    = GRANT;
          gnt_next      = idle_win_oh;
          sel_next      = idle_win;
          busy_next     = 1'b1;
          last_next     = idle_win;
          hold_cnt_next = 4'd0;
        end
      end
      GRANT: begin
        if (!bus.req[sel_reg] && others_req) begin
          gnt_next      = rot_win_oh;
          sel_next      = rot_win;
          last_next     = rot_win;
          hold_cnt_next = 4'd0;
        end else if (!bus.req[sel_reg]) begin
          state_next    = IDLE;
          gnt_next      = 4'b0000;
          busy_next     = 1'b0;
          hold_cnt_next = 4'd0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          if (others_req) begin
            gnt_next  = rot_win_oh;
            sel_next  = rot_win;
            last_next = rot_win;
          end
          hold_cnt_next = 4'd0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.gnt     = gnt_reg;
  assign bus.sel     = sel_reg;
  assign bus.busy    = busy_reg;
  assign bus.bus_out = busy_reg ? data_arr[sel_reg] : '0;
endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: a driver feeds directed and random
// requests through an ownership model; a negedge monitor checks each cycle.
module tb_bus_arbiter4;
  localparam int DATA_BITS = 8;
  localparam int MAX_HOLD  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter4_if #(.DATA_BITS(DATA_BITS)) bus ();

  bus_arbiter4 #(.DATA_BITS(DATA_BITS), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DATA_BITS-1:0] in_val [4];

  // Model state: current owner (-1 = none), cycles it has held so far,
  // who was granted most recently, and what sel shows.
  int m_owner = -1;
  int m_held = 0;
  int m_last = 3;
  int m_sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int next_after(input logic [3:0] r, input int base);
    for (int d = 1; d <= 4; d++) begin
      if (r[(base + d) % 4]) return (base + d) % 4;
    end
    return base;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] r);
    logic [3:0] others;
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner = next_after(r, m_last);
        m_held = 1;
      end
    end else begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner]) begin
        if (others != 4'b0) begin
          m_owner = next_after(others, m_owner);
          m_held = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_held == MAX_HOLD) begin
        if (others != 4'b0) m_owner = next_after(others, m_owner);
        m_held = 1;
      end else begin
        m_held++;
      end
    end
    if (m_owner >= 0) begin
      m_last = m_owner;
      m_sel = m_owner;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] r);
    exp_t e;
    reset = rst;
    bus.req = r;
    for (int i = 0; i < 4; i++) in_val[i] = DATA_BITS'($urandom);
    bus.in0 = in_val[0];
    bus.in1 = in_val[1];
    bus.in2 = in_val[2];
    bus.in3 = in_val[3];
    model_edge(rst, r);
    e.cyc  = cyc + 1;
    e.gnt  = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.busy = (m_owner >= 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v, input int c);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("stale_expectation", 32'(cyc), 32'(e.cyc), cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("gnt", 32'(bus.gnt), 32'(e.gnt), cyc);
      chk("sel", 32'(bus.sel), 32'(e.sel), cyc);
      chk("busy", 32'(bus.busy), 32'(e.busy), cyc);
      chk("bus_out", 32'(bus.bus_out), e.busy ? 32'(in_val[e.sel]) : 32'd0, cyc);
      $display("cyc=%0d req=%b gnt=%b sel=%0d busy=%b bus_out=%h", cyc, bus.req, bus.gnt, bus.sel, bus.busy, bus.bus_out);
    end
  end

  initial begin
    logic [3:0] r;
    bus.req = 4'b0;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    for (int i = 0; i < 4; i++) in_val[i] = '0;

    // Reset, single requester, then release
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001);
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0000);

    // Full contention: rotation every MAX_HOLD cycles
    for (int i = 0; i < 18; i++) step(1'b0, 4'b1111);

    // Owner 1 drops mid-grant; hand-over to 2 without idle gap
    step(1'b1, 4'b0000);
    for (int i = 0; i < 2; i++) step(1'b0, 4'b0110);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100);

    // Lone requester never loses the bus at the hold boundary
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);

    // Wrap-around from last=3
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1001);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000);
    step(1'b0, 4'b0000);

    // Reset in the middle of a grant, then priority restarts at requester 0
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100);
    step(1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0110);

    // Random traffic with sticky requests and rare resets
    r = 4'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step($urandom_range(0, 60) == 0, r);
    end
    step(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
